// File: rtl/pipe_hazard_ctl_if.sv
// Signal bundle between the pipeline datapath and its hazard/sequencing controller.
interface pipe_hazard_ctl_if;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        mem_branch;
    logic        mem_zero;
    logic        mem_memread;
    logic        mem_memwrite;
    logic        dmem_ready;
    logic        dmem_req;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_write;
    logic        exmem_write;
    logic        idex_bubble;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        pcsrc;
    logic        mem_err;
    logic [15:0] stall_cnt;

    modport master (
        output ex_memread, ex_rt, id_rs, id_rt, mem_branch, mem_zero,
               mem_memread, mem_memwrite, dmem_ready,
        input  dmem_req, pc_write, ifid_write, idex_write, exmem_write, idex_bubble,
               ifid_flush, idex_flush, exmem_flush, pcsrc, mem_err, stall_cnt
    );

    modport slave (
        input  ex_memread, ex_rt, id_rs, id_rt, mem_branch, mem_zero,
               mem_memread, mem_memwrite, dmem_ready,
        output dmem_req, pc_write, ifid_write, idex_write, exmem_write, idex_bubble,
               ifid_flush, idex_flush, exmem_flush, pcsrc, mem_err, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// Five-stage pipeline sequencer: memory-wait freeze, load-use bubble, taken-branch flush,
// plus a saturating stall counter and sticky memory-timeout flag.
module pipe_hazard_ctl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctl_if.slave bus
);

    typedef enum logic {StRun, StMemWait} state_t;

    state_t      state_q;
    logic [7:0]  wait_cnt_q;
    logic        err_q;
    logic [15:0] stall_q;

    logic memop;
    logic in_run;
    logic timed_out;
    logic advance;
    logic taken;
    logic load_use;
    logic pc_we;

    always_comb begin
        memop     = bus.mem_memread | bus.mem_memwrite;
        in_run    = (state_q == StRun);
        timed_out = (wait_cnt_q == 8'(TIMEOUT));
        advance   = in_run ? (!memop | bus.dmem_ready) : (bus.dmem_ready | timed_out);
        taken     = bus.mem_branch & bus.mem_zero & !memop;
        load_use  = !taken & bus.ex_memread & (bus.ex_rt != 5'd0) &
                    ((bus.ex_rt == bus.id_rs) | (bus.ex_rt == bus.id_rt));
        pc_we     = !rst & advance & !load_use;
    end

    // Outputs are forced low while reset is held, independent of the clock.
    always_comb begin
        bus.pc_write    = pc_we;
        bus.ifid_write  = pc_we;
        bus.idex_write  = !rst & advance;
        bus.exmem_write = !rst & advance;
        bus.idex_bubble = !rst & advance & load_use;
        bus.ifid_flush  = !rst & advance & taken;
        bus.idex_flush  = !rst & advance & taken;
        bus.exmem_flush = !rst & advance & taken;
        bus.pcsrc       = !rst & advance & taken;
        bus.dmem_req    = !rst & (in_run ? memop : 1'b1);
        bus.mem_err     = err_q;
        bus.stall_cnt   = stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
            stall_q    <= 16'd0;
        end else begin
            if (!pc_we && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            case (state_q)
                StRun: begin
                    if (memop && !bus.dmem_ready) begin
                        state_q    <= StMemWait;
                        wait_cnt_q <= 8'd0;
                    end
                end
                StMemWait: begin
                    if (advance) begin
                        state_q <= StRun;
                        // Leaving without a ready strobe means the access was abandoned.
                        if (!bus.dmem_ready) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scoreboard bench for pipe_hazard_ctl: driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_hazard_ctl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_hazard_ctl_if bus ();

    pipe_hazard_ctl #(.TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Flag order: pc_write ifid_write idex_write exmem_write | idex_bubble ifid_flush
    // idex_flush exmem_flush | pcsrc dmem_req mem_err
    localparam logic [10:0] ZERO = 11'b0000_0000_000;
    localparam logic [10:0] ADV  = 11'b1111_0000_000;
    localparam logic [10:0] ADVR = 11'b1111_0000_010;
    localparam logic [10:0] FRZ  = 11'b0000_0000_010;
    localparam logic [10:0] LU   = 11'b0011_1000_000;
    localparam logic [10:0] BR   = 11'b1111_0111_100;
    localparam logic [10:0] ERR  = 11'b0000_0000_001;

    typedef struct {
        string       name;
        logic [10:0] flags;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    task automatic drive(input logic em, input logic [4:0] ert, input logic [4:0] irs,
                         input logic [4:0] irt, input logic br, input logic zr,
                         input logic mrd, input logic mwr, input logic rdy);
        bus.ex_memread   = em;
        bus.ex_rt        = ert;
        bus.id_rs        = irs;
        bus.id_rt        = irt;
        bus.mem_branch   = br;
        bus.mem_zero     = zr;
        bus.mem_memread  = mrd;
        bus.mem_memwrite = mwr;
        bus.dmem_ready   = rdy;
    endtask

    task automatic apply(input string name, input logic em, input logic [4:0] ert,
                         input logic [4:0] irs, input logic [4:0] irt, input logic br,
                         input logic zr, input logic mrd, input logic mwr, input logic rdy,
                         input logic [10:0] f, input logic [15:0] sc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(em, ert, irs, irt, br, zr, mrd, mwr, rdy);
        e.name  = name;
        e.flags = f;
        e.sc    = sc;
        q.push_back(e);
    endtask

    task automatic expect_now(input string name, input logic [10:0] f, input logic [15:0] sc);
        exp_t e;
        e.name  = name;
        e.flags = f;
        e.sc    = sc;
        q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t        e;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
                       bus.idex_bubble, bus.ifid_flush, bus.idex_flush, bus.exmem_flush,
                       bus.pcsrc, bus.dmem_req, bus.mem_err};
                n_vec++;
                if (act !== e.flags || bus.stall_cnt !== e.sc) begin
                    n_fail++;
                    $display("FAIL %s: flags=%b stall_cnt=%h, required flags=%b stall_cnt=%h",
                             e.name, act, bus.stall_cnt, e.flags, e.sc);
                end
            end
        end
    end

    // Driver
    initial begin
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_now("reset_hold", ZERO, 16'd0);

        apply("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 16'd0);
        apply("loaduse_rs",       1, 8, 8, 0, 0, 0, 0, 0, 0, LU,  16'd0);
        apply("after_loaduse",    0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 16'd1);
        apply("ex_rt_zero",       1, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 16'd1);
        apply("loaduse_rt",       1, 5, 3, 5, 0, 0, 0, 0, 0, LU,  16'd1);
        apply("no_memread",       0, 5, 5, 0, 0, 0, 0, 0, 0, ADV, 16'd2);

        apply("miss_c0",          0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  16'd2);
        apply("miss_c1",          0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  16'd3);
        apply("miss_c2",          0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  16'd4);
        apply("miss_ready",       0, 0, 0, 0, 0, 0, 1, 0, 1, ADVR, 16'd5);
        apply("after_miss",       0, 0, 0, 0, 0, 0, 0, 0, 0, ADV,  16'd5);
        apply("zero_wait_write",  0, 0, 0, 0, 0, 0, 0, 1, 1, ADVR, 16'd5);
        apply("idle",             0, 0, 0, 0, 0, 0, 0, 0, 0, ADV,  16'd5);
        apply("stray_ready",      0, 0, 0, 0, 0, 0, 0, 0, 1, ADV,  16'd5);
        apply("branch_over_lu",   1, 8, 8, 0, 1, 1, 0, 0, 0, BR,   16'd5);
        apply("branch_with_memop",0, 0, 0, 0, 1, 1, 1, 0, 1, ADVR, 16'd5);
        apply("branch_not_zero",  0, 0, 0, 0, 1, 0, 0, 0, 0, ADV,  16'd5);

        apply("timeout_c0",       0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ,  16'd5);
        for (int i = 0; i < 15; i++) begin
            apply("timeout_wait", 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ, 16'(6 + i));
        end
        apply("timeout_advance",  0, 0, 0, 0, 0, 0, 1, 0, 0, ADVR,      16'd21);
        apply("err_set",          0, 0, 0, 0, 0, 0, 0, 0, 0, ADV | ERR, 16'd21);
        apply("err_sticky",       0, 0, 0, 0, 0, 0, 0, 0, 0, ADV | ERR, 16'd21);

        apply("pre_reset_c0",     0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ | ERR, 16'd21);
        apply("pre_reset_wait",   0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ | ERR, 16'd22);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_now("reset_mid_wait", ZERO, 16'd0);
        apply("release_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 16'd0);

        // Hold a load-use stall long enough to reach the counter ceiling.
        @(posedge clk);
        #1;
        drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        apply("sat_lu",           1, 8, 8, 0, 0, 0, 0, 0, 0, LU,  16'hFFFF);
        apply("sat_hold",         0, 0, 0, 0, 0, 0, 0, 0, 0, ADV, 16'hFFFF);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            begin
                #2_000_000;
                n_fail++;
                $display("FAIL watchdog: bench did not complete, required completion");
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
